muldiv_ctrl: RTL and testbench

- Multi-cycle multiply/divide controller for the 5-stage pipeline. It owns the HI/LO registers and sequences one MULT/MULTU/DIV/DIVU at a time.
- Launched from the EXE stage. Raises a stall request toward ID while an instruction there needs the unit and the unit is busy or being launched.
- Shares the single mult/div resource across back-to-back instructions without corrupting HI/LO.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_ctrl_md_arith.sv | 39 +++
 rtl/muldiv_ctrl.sv | 125 ++++++++++++
 tb/tb_muldiv_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and default latencies for the multiply/divide controller.
package muldiv_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int unsigned DEF_MULT_LAT = 5;
  localparam int unsigned DEF_DIV_LAT  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/muldiv_ctrl_md_arith.sv
// Combinational 32x32 multiply and 32/32 divide, signed or unsigned.
// Operands are widened by one sign/zero bit so one signed datapath covers both.
module md_arith (
  input  logic        is_signed,
  input  logic        is_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_n,
  output logic [31:0] lo_n,
  output logic        div_zero
);

  logic [63:0] a64, b64, prod;
  logic [32:0] a33, b33, quot33, rem33;
  logic        unused_msb;

  assign a64  = {{32{is_signed & a[31]}}, a};
  assign b64  = {{32{is_signed & b[31]}}, b};
  assign prod = a64 * b64;

  assign a33 = {is_signed & a[31], a};
  assign b33 = {is_signed & b[31], b};

  // 33-bit signed divide keeps 0x80000000 / -1 representable (quotient +2^31).
  always_comb begin
    quot33 = '0;
    rem33  = '0;
    if (b != 32'd0) begin
      quot33 = $signed(a33) / $signed(b33);
      rem33  = $signed(a33) % $signed(b33);
    end
  end

  assign unused_msb = quot33[32] ^ rem33[32];
  assign div_zero   = is_div & (b == 32'd0);
  assign hi_n       = is_div ? rem33[31:0]  : prod[63:32];
  assign lo_n       = is_div ? quot33[31:0] : prod[31:0];

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/DIV sequencer owning HI/LO; optional abort via MUL_DIV_CANCEL_EN.
//   state   | meaning
//   ST_IDLE | no op in flight; MTHI/MTLO write directly, MULT/DIV launch
//   ST_BUSY | result held in pending regs, count runs down to commit
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned MULT_LAT = DEF_MULT_LAT,
  parameter int unsigned DIV_LAT  = DEF_DIV_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  input  logic        d_md_use,
  input  logic        md_cancel,
  output logic        busy,
  output logic        done,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e      state, state_n;
  logic [4:0]  count, count_n;
  logic [31:0] pend_hi, pend_lo;
  logic        pend_dz;
  logic [31:0] hi_n, lo_n;
  logic        div_zero;
  logic        is_md, cancel, start_ok;
  logic        load_pend, commit, wr_hi, wr_lo, done_n;

`ifdef MUL_DIV_CANCEL_EN
  assign cancel = md_cancel;
`else
  logic unused_cancel;
  assign unused_cancel = md_cancel;
  assign cancel        = 1'b0;
`endif

  assign is_md    = ~md_op[2];
  assign start_ok = md_start & ~cancel;
  assign busy     = (state == ST_BUSY);
  assign md_stall = d_md_use & (busy | (md_start & is_md));

  md_arith u_arith (
    .is_signed (~md_op[0]),
    .is_div    (md_op[1]),
    .a         (md_a),
    .b         (md_b),
    .hi_n      (hi_n),
    .lo_n      (lo_n),
    .div_zero  (div_zero)
  );

  always_comb begin
    state_n   = state;
    count_n   = count;
    load_pend = 1'b0;
    commit    = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    done_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) begin
          if (is_md) begin
            load_pend = 1'b1;
            state_n   = ST_BUSY;
            count_n   = md_op[1] ? 5'(DIV_LAT - 1) : 5'(MULT_LAT - 1);
          end else if (md_op == MD_MTHI) begin
            wr_hi = 1'b1;
          end else if (md_op == MD_MTLO) begin
            wr_lo = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (cancel) begin
          state_n = ST_IDLE;
          count_n = '0;
        end else if (count == 5'd0) begin
          commit  = 1'b1;
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end else begin
          count_n = count - 5'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      count   <= '0;
      done    <= 1'b0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_dz <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      done  <= done_n;
      if (load_pend) begin
        pend_hi <= hi_n;
        pend_lo <= lo_n;
        pend_dz <= div_zero;
      end
      // Divide by zero still runs the full latency but leaves HI/LO alone.
      if (commit && !pend_dz) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
      if (wr_hi) hi <= md_a;
      if (wr_lo) lo <= md_a;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl (cancel checks follow MUL_DIV_CANCEL_EN).
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] md_a, md_b;
  logic        d_md_use;
  logic        md_cancel;
  logic        busy, done, md_stall;
  logic [31:0] hi, lo;

  int vectors = 0;
  int errs    = 0;

  muldiv_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .md_start  (md_start),
    .md_op     (md_op),
    .md_a      (md_a),
    .md_b      (md_b),
    .d_md_use  (d_md_use),
    .md_cancel (md_cancel),
    .busy      (busy),
    .done      (done),
    .md_stall  (md_stall),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch one op, measure busy length, check result and a single done pulse.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    md_start = 1'b1; md_op = op; md_a = a; md_b = b;
    tick();
    md_start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk({tag, "_busy_len"}, 32'(n), 32'(lat));
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
    tick();
    chk({tag, "_done_once"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; md_start = 1'b0; md_op = 3'd7; md_a = '0; md_b = '0;
    d_md_use = 1'b0; md_cancel = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    // MULT -2*3 with a dependent MFLO in ID and a stray start mid-busy
    d_md_use = 1'b1;
    md_start = 1'b1; md_op = 3'd0; md_a = 32'hFFFF_FFFE; md_b = 32'd3;
    #1 chk("stall_start", {31'd0, md_stall}, 32'd1);
    tick();
    md_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        md_start = 1'b1; md_op = 3'd2; md_a = 32'd100; md_b = 32'd7;
      end else begin
        md_start = 1'b0;
      end
      #1;
      chk($sformatf("mult_busy_%0d", i), {31'd0, busy}, 32'd1);
      chk($sformatf("mult_stall_%0d", i), {31'd0, md_stall}, 32'd1);
      chk($sformatf("mult_hold_%0d", i), hi, 32'd0);
      tick();
    end
    md_start = 1'b0;
    chk("mult_busy_end", {31'd0, busy}, 32'd0);
    chk("mult_stall_end", {31'd0, md_stall}, 32'd0);
    chk("mult_done", {31'd0, done}, 32'd1);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    tick();
    chk("mult_done_once", {31'd0, done}, 32'd0);
    chk("mult_no_requeue", {31'd0, busy}, 32'd0);

    // Stall only when ID needs the unit, and only for ops 0..3
    d_md_use = 1'b0;
    md_start = 1'b1; md_op = 3'd0;
    #1 chk("stall_no_use", {31'd0, md_stall}, 32'd0);
    d_md_use = 1'b1; md_op = 3'd4;
    #1 chk("stall_mthi", {31'd0, md_stall}, 32'd0);
    md_start = 1'b0; d_md_use = 1'b0;

    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_zero", 3'd3, 32'd7, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);
    run_op("divu", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'h0000_0001, 32'h7FFF_FFFC);

    // MTHI / MTLO / no-op in IDLE
    md_start = 1'b1; md_op = 3'd4; md_a = 32'h1234_5678;
    tick();
    md_start = 1'b0;
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_done", {31'd0, done}, 32'd0);
    md_start = 1'b1; md_op = 3'd5; md_a = 32'hCAFE_F00D;
    tick();
    chk("mtlo_lo", lo, 32'hCAFE_F00D);
    chk("mtlo_hi", hi, 32'h1234_5678);
    md_op = 3'd6; md_a = 32'hDEAD_BEEF;
    tick();
    md_start = 1'b0;
    chk("nop_busy", {31'd0, busy}, 32'd0);
    chk("nop_hi", hi, 32'h1234_5678);
    chk("nop_lo", lo, 32'hCAFE_F00D);

    // Cancel at busy cycle 3 of a MULT 3*4
    md_start = 1'b1; md_op = 3'd0; md_a = 32'd3; md_b = 32'd4;
    tick();
    md_start = 1'b0;
    tick(); tick();
    md_cancel = 1'b1;
    tick();
    md_cancel = 1'b0;
`ifdef MUL_DIV_CANCEL_EN
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    chk("cancel_done", {31'd0, done}, 32'd0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1) n++;
      tick();
    end
    chk("cancel_no_done", 32'(n), 32'd0);
    chk("cancel_hi", hi, 32'h1234_5678);
    chk("cancel_lo", lo, 32'hCAFE_F00D);
    md_start = 1'b1; md_op = 3'd4; md_a = 32'h5555_AAAA; md_cancel = 1'b1;
    tick();
    md_start = 1'b0; md_cancel = 1'b0;
    chk("cancel_drops_start", hi, 32'h1234_5678);
`else
    chk("nocancel_busy", {31'd0, busy}, 32'd1);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    chk("nocancel_rest", 32'(n), 32'd2);
    chk("nocancel_done", {31'd0, done}, 32'd1);
    chk("nocancel_hi", hi, 32'd0);
    chk("nocancel_lo", lo, 32'd12);
    tick();
`endif

    // Reset for two cycles in the middle of a DIV
    md_start = 1'b1; md_op = 3'd2; md_a = 32'd100; md_b = 32'd7;
    tick();
    md_start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_hi", hi, 32'd0);
    chk("mid_rst_lo", lo, 32'd0);
    n = 0;
    for (int i = 0; i < 15; i++) begin
      if (done === 1'b1 || lo !== 32'd0 || hi !== 32'd0) n++;
      tick();
    end
    chk("mid_rst_no_result", 32'(n), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
